// File: rtl/piece_move_ctrl_pkg.sv
// Shared types and constants for the falling-piece movement controller.
package piece_move_ctrl_pkg;

  localparam int X_W   = 4;
  localparam int Y_W   = 5;
  localparam int ROT_W = 2;

  localparam logic [2:0] MODE_PLAY = 3'd1;

  localparam logic [X_W-1:0]   SPAWN_X   = 4'd4;
  localparam logic [Y_W-1:0]   SPAWN_Y   = 5'd0;
  localparam logic [ROT_W-1:0] SPAWN_ROT = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_READY,
    ST_CHECK,
    ST_LOCK,
    ST_LOCK_WAIT,
    ST_OVER
  } state_t;

  // Enum order doubles as arbitration priority: lower value wins.
  localparam int NUM_REQ = 5;
  typedef enum logic [2:0] {
    REQ_TICK,
    REQ_LEFT,
    REQ_RIGHT,
    REQ_ROTATE,
    REQ_DOWN
  } req_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ROT_W-1:0] rot;
  } place_t;

  localparam place_t SPAWN_PLACE = '{x: SPAWN_X, y: SPAWN_Y, rot: SPAWN_ROT};

  // Wrapping arithmetic at port widths; off-board candidates are the checker's call.
  function automatic place_t move_place(place_t p, req_t r);
    place_t n;
    n = p;
    case (r)
      REQ_TICK,
      REQ_DOWN:   n.y   = p.y + Y_W'(1);
      REQ_LEFT:   n.x   = p.x - X_W'(1);
      REQ_RIGHT:  n.x   = p.x + X_W'(1);
      REQ_ROTATE: n.rot = p.rot + ROT_W'(1);
      default:    n     = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/move_req_arbiter.sv
// Sticky pending bits for move requests with a fixed-priority single grant.
module move_req_arbiter
  import piece_move_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               latch_en,
  input  logic               clear_all,
  input  logic               grant_en,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic               grant_valid,
  output req_t               grant_kind
);

  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_n;
  logic [NUM_REQ-1:0] grant_mask;

  always_comb begin
    grant_valid = 1'b0;
    grant_kind  = REQ_TICK;
    grant_mask  = '0;
    if (grant_en) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          grant_valid = 1'b1;
          grant_kind  = req_t'(3'(i));
          grant_mask  = NUM_REQ'(1) << i;
        end
      end
    end
  end

  // A pulse landing on the cycle its bit is granted survives the clear.
  always_comb begin
    pending_n = '0;
    if (!clear_all)
      pending_n = (pending_q & ~grant_mask) | (latch_en ? req_pulse : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_n;
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Movement/lock sequencer for the active piece: arbitrates move requests,
// runs collision checks through an external checker and handles spawn/lock.
//
// state        | meaning
// IDLE         | not playing; waits for mode=PLAY
// SPAWN        | spawn placement under check
// READY        | piece placed, waiting for a pending request
// CHECK        | candidate placement under check
// LOCK         | lock_req pulse cycle
// LOCK_WAIT    | waiting for board write / line clear
// OVER         | spawn collided; only reset leaves
module piece_move_ctrl
  import piece_move_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             tick,
  input  logic             btn_left_en,
  input  logic             btn_right_en,
  input  logic             btn_rotate_en,
  input  logic             btn_down_en,
  output logic             check_req,
  input  logic             check_ack,
  input  logic             check_hit,
  output logic [X_W-1:0]   test_pos_x,
  output logic [Y_W-1:0]   test_pos_y,
  output logic [ROT_W-1:0] test_rot,
  output logic [X_W-1:0]   cur_pos_x,
  output logic [Y_W-1:0]   cur_pos_y,
  output logic [ROT_W-1:0] cur_rot,
  output logic             lock_req,
  input  logic             lock_done,
  output logic             game_over
);

  state_t state_q, state_n;
  place_t test_q, test_n;
  place_t cur_q, cur_n;
  logic   check_req_q, check_req_n;
  logic   lock_req_q, lock_req_n;
  logic   game_over_q, game_over_n;
  logic   fall_q, fall_n;

  logic   playing;
  logic   latch_en;
  logic   clear_all;
  logic   grant_en;
  logic   grant_valid;
  req_t   grant_kind;

  assign playing   = (mode == MODE_PLAY);
  assign latch_en  = playing && (state_q != ST_IDLE) && (state_q != ST_OVER);
  assign clear_all = !playing || (state_q == ST_IDLE) || (state_q == ST_OVER) ||
                     (state_q == ST_LOCK);
  assign grant_en  = playing && (state_q == ST_READY);

  move_req_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .latch_en    (latch_en),
    .clear_all   (clear_all),
    .grant_en    (grant_en),
    .req_pulse   ({btn_down_en, btn_rotate_en, btn_right_en, btn_left_en, tick}),
    .grant_valid (grant_valid),
    .grant_kind  (grant_kind)
  );

  always_comb begin
    state_n     = state_q;
    test_n      = test_q;
    cur_n       = cur_q;
    check_req_n = check_req_q;
    lock_req_n  = lock_req_q;
    game_over_n = game_over_q;
    fall_n      = fall_q;

    if (!playing && state_q != ST_OVER) begin
      state_n     = ST_IDLE;
      check_req_n = 1'b0;
      lock_req_n  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n     = ST_SPAWN;
          test_n      = SPAWN_PLACE;
          check_req_n = 1'b1;
        end
        ST_SPAWN: begin
          if (check_ack) begin
            check_req_n = 1'b0;
            if (check_hit) begin
              game_over_n = 1'b1;
              state_n     = ST_OVER;
            end else begin
              cur_n   = test_q;
              state_n = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (grant_valid) begin
            test_n      = move_place(cur_q, grant_kind);
            fall_n      = (grant_kind == REQ_TICK) || (grant_kind == REQ_DOWN);
            check_req_n = 1'b1;
            state_n     = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (check_ack) begin
            check_req_n = 1'b0;
            if (!check_hit) begin
              cur_n   = test_q;
              state_n = ST_READY;
            end else if (fall_q) begin
              lock_req_n = 1'b1;
              state_n    = ST_LOCK;
            end else begin
              state_n = ST_READY;
            end
          end
        end
        ST_LOCK: begin
          lock_req_n = 1'b0;
          state_n    = ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (lock_done) begin
            test_n      = SPAWN_PLACE;
            check_req_n = 1'b1;
            state_n     = ST_SPAWN;
          end
        end
        ST_OVER: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      test_q      <= SPAWN_PLACE;
      cur_q       <= SPAWN_PLACE;
      check_req_q <= 1'b0;
      lock_req_q  <= 1'b0;
      game_over_q <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      test_q      <= test_n;
      cur_q       <= cur_n;
      check_req_q <= check_req_n;
      lock_req_q  <= lock_req_n;
      game_over_q <= game_over_n;
      fall_q      <= fall_n;
    end
  end

  assign check_req  = check_req_q;
  assign lock_req   = lock_req_q;
  assign game_over  = game_over_q;
  assign test_pos_x = test_q.x;
  assign test_pos_y = test_q.y;
  assign test_rot   = test_q.rot;
  assign cur_pos_x  = cur_q.x;
  assign cur_pos_y  = cur_q.y;
  assign cur_rot    = cur_q.rot;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Scoreboard bench for piece_move_ctrl: expected check placements are queued
// by the stimulus and compared by a monitor on each new check_req.
module tb_piece_move_ctrl;
  import piece_move_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       mode = 3'd0;
  logic             tick = 1'b0, btn_left_en = 1'b0, btn_right_en = 1'b0;
  logic             btn_rotate_en = 1'b0, btn_down_en = 1'b0;
  logic             check_req, check_ack = 1'b0, check_hit = 1'b0;
  logic [3:0]       test_pos_x, cur_pos_x;
  logic [4:0]       test_pos_y, cur_pos_y;
  logic [1:0]       test_rot, cur_rot;
  logic             lock_req, lock_done = 1'b0, game_over;

  always #5 clk = ~clk;

  piece_move_ctrl dut (
    .clk(clk), .rst(rst), .mode(mode), .tick(tick),
    .btn_left_en(btn_left_en), .btn_right_en(btn_right_en),
    .btn_rotate_en(btn_rotate_en), .btn_down_en(btn_down_en),
    .check_req(check_req), .check_ack(check_ack), .check_hit(check_hit),
    .test_pos_x(test_pos_x), .test_pos_y(test_pos_y), .test_rot(test_rot),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_rot(cur_rot),
    .lock_req(lock_req), .lock_done(lock_done), .game_over(game_over)
  );

  localparam logic [4:0] P_TICK = 5'b00001, P_LEFT = 5'b00010, P_RIGHT = 5'b00100,
                         P_ROT = 5'b01000, P_DOWN = 5'b10000;

  int     n_vec = 0;
  int     n_err = 0;
  int     chk_cnt = 0;
  int     lock_cnt = 0;
  logic   prev_req = 1'b0;
  place_t exp_q[$];
  place_t cur_pl, test_pl;

  assign cur_pl  = '{x: cur_pos_x, y: cur_pos_y, rot: cur_rot};
  assign test_pl = '{x: test_pos_x, y: test_pos_y, rot: test_rot};

  function automatic place_t pl(int x, int y, int r);
    return '{x: 4'(x), y: 5'(y), rot: 2'(r)};
  endfunction

  // Monitor: every rising check_req must match the next queued placement.
  always @(negedge clk) begin
    if (check_req && !prev_req) begin
      place_t e;
      n_vec++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_check: got x=%0d y=%0d rot=%0d, none expected",
                 test_pos_x, test_pos_y, test_rot);
      end else begin
        e = exp_q.pop_front();
        if (test_pl !== e) begin
          n_err++;
          $display("FAIL check_place: got x=%0d y=%0d rot=%0d expected x=%0d y=%0d rot=%0d",
                   test_pos_x, test_pos_y, test_rot, e.x, e.y, e.rot);
        end
      end
    end
    if (lock_req) lock_cnt++;
    prev_req = check_req;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cur(string name, place_t e);
    n_vec++;
    if (cur_pl !== e) begin
      n_err++;
      $display("FAIL %s: got cur x=%0d y=%0d rot=%0d expected x=%0d y=%0d rot=%0d",
               name, cur_pos_x, cur_pos_y, cur_rot, e.x, e.y, e.rot);
    end
  endtask

  task automatic pulse(logic [4:0] m);
    {btn_down_en, btn_rotate_en, btn_right_en, btn_left_en, tick} = m;
    @(negedge clk);
    {btn_down_en, btn_rotate_en, btn_right_en, btn_left_en, tick} = 5'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (check_req) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL check_req_timeout: got check_req=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic ack(logic hit);
    bit ok;
    wait_req(ok);
    if (ok) begin
      check_ack = 1'b1;
      check_hit = hit;
      @(negedge clk);
      check_ack = 1'b0;
      check_hit = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int lock_before, chk_before;
    repeat (2) @(negedge clk);
    chk("rst_state", dut.state_q, ST_IDLE);
    chk_cur("rst_cur", pl(4, 0, 0));
    chk("rst_test", test_pl, pl(4, 0, 0));
    chk("rst_check_req", check_req, 0);
    chk("rst_lock_req", lock_req, 0);
    chk("rst_game_over", game_over, 0);

    // Spawn from reset
    rst = 1'b0;
    exp_q.push_back(pl(4, 0, 0));
    mode = 3'd1;
    ack(1'b0);
    chk("spawn_state", dut.state_q, ST_READY);
    chk_cur("spawn_cur", pl(4, 0, 0));
    chk("spawn_req_drop", check_req, 0);

    // lock_done outside LOCK_WAIT is ignored
    lock_done = 1'b1;
    @(negedge clk);
    lock_done = 1'b0;
    @(negedge clk);
    chk("stray_lock_done_state", dut.state_q, ST_READY);
    chk("stray_lock_done_req", check_req, 0);

    // Left and rotate together: left first, then rotate
    chk_before = chk_cnt;
    exp_q.push_back(pl(3, 0, 0));
    exp_q.push_back(pl(3, 0, 1));
    pulse(P_LEFT | P_ROT);
    ack(1'b0);
    ack(1'b0);
    @(negedge clk);
    chk_cur("left_rot_cur", pl(3, 0, 1));
    chk("left_rot_checks", chk_cnt - chk_before, 2);

    // Walk to x=0, then left wraps to 15 and is rejected
    for (int x = 2; x >= 0; x--) begin
      exp_q.push_back(pl(x, 0, 1));
      pulse(P_LEFT);
      ack(1'b0);
    end
    chk_cur("walk_left_cur", pl(0, 0, 1));
    lock_before = lock_cnt;
    exp_q.push_back(pl(15, 0, 1));
    pulse(P_LEFT);
    ack(1'b1);
    repeat (2) @(negedge clk);
    chk_cur("wrap_reject_cur", pl(0, 0, 1));
    chk("wrap_no_lock", lock_cnt - lock_before, 0);
    chk("wrap_state", dut.state_q, ST_READY);

    // Fall to y=19 alternating tick/down
    for (int y = 0; y < 19; y++) begin
      exp_q.push_back(pl(0, y + 1, 1));
      pulse((y % 2) ? P_DOWN : P_TICK);
      ack(1'b0);
    end
    chk_cur("fall_cur", pl(0, 19, 1));

    // Tick at y=19 hits: lock then respawn
    lock_before = lock_cnt;
    exp_q.push_back(pl(0, 20, 1));
    pulse(P_TICK);
    ack(1'b1);
    repeat (3) @(negedge clk);
    chk("lock_pulses", lock_cnt - lock_before, 1);
    chk("lock_req_low", lock_req, 0);
    chk("lock_wait_state", dut.state_q, ST_LOCK_WAIT);
    chk_cur("lock_cur_hold", pl(0, 19, 1));
    exp_q.push_back(pl(4, 0, 0));
    lock_done = 1'b1;
    @(negedge clk);
    lock_done = 1'b0;
    ack(1'b0);
    chk_cur("respawn_cur", pl(4, 0, 0));

    // Tick beats right; right then rejected
    exp_q.push_back(pl(4, 1, 0));
    exp_q.push_back(pl(5, 1, 0));
    pulse(P_TICK | P_RIGHT);
    ack(1'b0);
    ack(1'b1);
    @(negedge clk);
    chk_cur("prio_cur", pl(4, 1, 0));

    // Leaving PLAY mid-check
    exp_q.push_back(pl(3, 1, 0));
    pulse(P_LEFT);
    wait_req(ok);
    mode = 3'd0;
    @(negedge clk);
    chk("abort_check_req", check_req, 0);
    chk("abort_state", dut.state_q, ST_IDLE);
    chk_cur("abort_cur", pl(4, 1, 0));

    // Spawn collision -> OVER
    exp_q.push_back(pl(4, 0, 0));
    mode = 3'd1;
    ack(1'b1);
    chk("over_game_over", game_over, 1);
    chk("over_state", dut.state_q, ST_OVER);
    chk_before = chk_cnt;
    pulse(P_LEFT | P_TICK);
    repeat (8) @(negedge clk);
    chk("over_no_checks", chk_cnt - chk_before, 0);
    mode = 3'd0;
    @(negedge clk);
    chk("over_sticky_state", dut.state_q, ST_OVER);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_over", game_over, 0);
    chk("rst_over_state", dut.state_q, ST_IDLE);
    chk_cur("rst_over_cur", pl(4, 0, 0));

    // Reset mid spawn-check
    exp_q.push_back(pl(4, 0, 0));
    mode = 3'd1;
    wait_req(ok);
    rst  = 1'b1;
    mode = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_check_req", check_req, 0);
    chk("rst_mid_state", dut.state_q, ST_IDLE);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/piece_move_ctrl.md
PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: mode  in  3  game mode; 3'd1 = PLAY, any other value = not playing.
REQ-004 SHALL have ports: tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en  in  1 each  single-cycle request pulses.
REQ-005 SHALL have ports: check_req  out  1  collision check request; check_ack  in  1  check complete; check_hit  in  1  collision result, valid only while check_ack=1.
REQ-006 SHALL have ports: test_pos_x  out  4, test_pos_y  out  5, test_rot  out  2  candidate placement, registered.
REQ-007 SHALL have ports: cur_pos_x  out  4, cur_pos_y  out  5, cur_rot  out  2  committed placement, registered.
REQ-008 SHALL have ports: lock_req  out  1  piece-lock pulse; lock_done  in  1  board write and line clear finished.
REQ-009 SHALL have ports: game_over  out  1  sticky, set when spawn collides.

Function
REQ-010 SHALL run FSM states IDLE, SPAWN, READY, CHECK, LOCK, LOCK_WAIT, OVER.
REQ-011 SHALL latch each request pulse into a sticky pending bit, in every state except IDLE and OVER.
REQ-012 SHALL give set priority over clear when a pulse arrives in the same cycle that its pending bit is granted.
REQ-013 In READY with pending bits set, SHALL grant exactly one per priority: tick > left > right > rotate > down.
REQ-014 On grant, SHALL clear the granted bit, load test_* from cur_* (tick/down: y+1; left: x-1; right: x+1; rotate: rot+1), assert check_req from the next cycle and enter CHECK.
REQ-015 SHALL hold check_req and test_* stable until check_ack=1, then deassert check_req in the following cycle.
REQ-016 On check_ack with check_hit=0, SHALL copy test_* into cur_* at that edge and return to READY.
REQ-017 On check_ack with check_hit=1 for left/right/rotate, SHALL leave cur_* unchanged and return to READY.
REQ-018 On check_ack with check_hit=1 for tick/down, SHALL enter LOCK.
REQ-019 In LOCK, SHALL pulse lock_req for one cycle, enter LOCK_WAIT, clear all pending bits, and wait for lock_done.
REQ-020 On lock_done, SHALL enter SPAWN.
REQ-021 In SPAWN, SHALL load test_* = (x=4, y=0, rot=0) and issue a check.
REQ-022 If the spawn check has no hit, SHALL commit the spawn placement and enter READY.
REQ-023 If the spawn check hits, SHALL set game_over and enter OVER.
REQ-024 SHALL use modulo arithmetic matching the port widths (x=0 left gives 15; rot=3 rotate gives 0); bounds rejection is the checker's job via check_hit.
REQ-025 In IDLE, SHALL enter SPAWN when mode=PLAY.
REQ-026 SHALL leave OVER only on reset.
REQ-027 When mode leaves PLAY in any state other than OVER, SHALL drop check_req and enter IDLE next cycle, clearing pending bits; cur_* SHALL hold.
REQ-028 SHALL ignore check_ack outside CHECK and spawn-check, and ignore lock_done outside LOCK_WAIT.

Reset
REQ-029 On rst, SHALL set state=IDLE, pending=0, cur_*=test_*=(4,0,0), check_req=0, lock_req=0, game_over=0.
REQ-030 SHALL give rst priority over all other inputs, including mid-check and mid-lock.

Structure
REQ-031 SHALL define in a shared package: mode encodings, FSM state encodings, spawn constants (4,0,0), and the X/Y/ROT widths.
REQ-032 SHALL place request latching and fixed-priority grant in one sub-module, move_req_arbiter.

Verification
REQ-033 SHALL verify: PLAY from reset, spawn check ack hit=0 -> cur=(4,0,0) and state READY.
REQ-034 SHALL verify: btn_left_en and btn_rotate_en in the same cycle, both acks hit=0 -> left committed first (x=3), then rot=1; two check_req cycles are observed.
REQ-035 SHALL verify: x=0 with btn_left_en -> test_pos_x=15; ack hit=1 -> cur_pos_x stays 0 and no lock_req.
REQ-036 SHALL verify: tick at y=19, ack hit=1 -> one lock_req pulse; after lock_done, spawn check issued with test=(4,0,0).
REQ-037 SHALL verify: spawn check hit=1 -> game_over=1 and state OVER; later button pulses produce no check_req; rst clears game_over.
REQ-038 SHALL verify: mode changed to 0 while check_req=1 -> check_req=0 next cycle, state IDLE, cur_* unchanged.
